// File: rtl/key_cmd_pkg.sv
// Shared scan codes, FSM states and held-flag indices
// for the PS/2 keyboard command sequencer.
package key_cmd_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_L     = 8'h4B;
  localparam logic [7:0] SC_P     = 8'h4D;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_e;

  typedef logic [2:0] key_t;

  localparam key_t K_L     = 3'd0;
  localparam key_t K_P     = 3'd1;
  localparam key_t K_SPACE = 3'd2;
  localparam key_t K_UP    = 3'd3;
  localparam key_t K_DOWN  = 3'd4;
  localparam key_t K_LEFT  = 3'd5;
  localparam key_t K_RIGHT = 3'd6;
  localparam key_t K_NONE  = 3'd7;

  localparam int NUM_KEYS = 7;

  function automatic key_t base_key(logic [7:0] c);
    case (c)
      SC_L:     return K_L;
      SC_P:     return K_P;
      SC_SPACE: return K_SPACE;
      default:  return K_NONE;
    endcase
  endfunction

  function automatic key_t ext_key(logic [7:0] c);
    case (c)
      SC_UP:    return K_UP;
      SC_DOWN:  return K_DOWN;
      SC_LEFT:  return K_LEFT;
      SC_RIGHT: return K_RIGHT;
      default:  return K_NONE;
    endcase
  endfunction

endpackage

// File: rtl/key_cmd_fsm_prefix_timer.sv
// Idle-cycle counter bounding the gap between a prefix
// byte and the byte that completes it.
module prefix_timer #(
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/key_cmd_fsm.sv
// Turns PS/2 scan bytes into tuner commands: mode,
// note cursor, octave and a one-cycle play strobe.
module key_cmd_fsm
  import key_cmd_pkg::*;
#(
  parameter int NUM_NOTES      = 8,
  parameter int NUM_OCT        = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  localparam int CW =
    (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1,
  localparam int OW =
    (NUM_OCT > 1) ? $clog2(NUM_OCT) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_done_tick,
  input  logic [7:0]           rx_data,
  output logic                 rx_en,
  output logic                 mode,
  output logic [CW-1:0]        cursor,
  output logic [NUM_NOTES-1:0] note_array,
  output logic [OW-1:0]        octave,
  output logic                 play_tick
);

  localparam logic [CW-1:0] CUR_LAST = CW'(NUM_NOTES - 1);
  localparam logic [OW-1:0] OCT_LAST = OW'(NUM_OCT - 1);

  state_e                state_q, state_d;
  logic [NUM_KEYS-1:0]   held_q, held_d;
  logic                  mode_q, mode_d;
  logic [CW-1:0]         cur_q, cur_d;
  logic [OW-1:0]         oct_q, oct_d;
  logic                  play_q, play_d;
  logic                  rx_en_q;
  logic                  tmr_clr, tmr_en, tmr_tc;
  logic                  make_v, brk_v;
  key_t                  key;

  assign tmr_clr = rx_done_tick || (state_q == IDLE);
  assign tmr_en  = !tmr_clr;

  prefix_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_o  (tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    mode_d  = mode_q;
    cur_d   = cur_q;
    oct_d   = oct_q;
    play_d  = 1'b0;
    make_v  = 1'b0;
    brk_v   = 1'b0;
    key     = K_NONE;
    if (rx_done_tick) begin
      unique case (state_q)
        IDLE: begin
          if (rx_data == SC_EXT) begin
            state_d = EXT;
          end else if (rx_data == SC_BRK) begin
            state_d = BRK;
          end else begin
            make_v = 1'b1;
            key    = base_key(rx_data);
          end
        end
        EXT: begin
          if (rx_data == SC_BRK) begin
            state_d = EXT_BRK;
          end else if (rx_data != SC_EXT) begin
            make_v  = 1'b1;
            key     = ext_key(rx_data);
            state_d = IDLE;
          end
        end
        BRK: begin
          brk_v   = 1'b1;
          key     = base_key(rx_data);
          state_d = IDLE;
        end
        EXT_BRK: begin
          brk_v   = 1'b1;
          key     = ext_key(rx_data);
          state_d = IDLE;
        end
      endcase
    end else if (tmr_tc) begin
      state_d = IDLE;
    end

    // Held flag filters typematic repeats of a make code
    if (key != K_NONE) begin
      if (brk_v) begin
        held_d[key] = 1'b0;
      end else if (make_v && !held_q[key]) begin
        held_d[key] = 1'b1;
        case (key)
          K_L: mode_d = 1'b0;
          K_P: mode_d = 1'b1;
          K_RIGHT: if (mode_q) begin
            cur_d = (cur_q == CUR_LAST) ? '0 : cur_q + CW'(1);
          end
          K_LEFT: if (mode_q) begin
            cur_d = (cur_q == '0) ? CUR_LAST : cur_q - CW'(1);
          end
          K_UP: if (mode_q && (oct_q != OCT_LAST)) begin
            oct_d = oct_q + OW'(1);
          end
          K_DOWN: if (mode_q && (oct_q != '0)) begin
            oct_d = oct_q - OW'(1);
          end
          K_SPACE: play_d = mode_q;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      held_q  <= '0;
      mode_q  <= 1'b0;
      cur_q   <= '0;
      oct_q   <= '0;
      play_q  <= 1'b0;
      rx_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      mode_q  <= mode_d;
      cur_q   <= cur_d;
      oct_q   <= oct_d;
      play_q  <= play_d;
      rx_en_q <= 1'b1;
    end
  end

  assign rx_en      = rx_en_q;
  assign mode       = mode_q;
  assign cursor     = cur_q;
  assign octave     = oct_q;
  assign play_tick  = play_q;
  assign note_array =
    {{(NUM_NOTES-1){1'b0}}, 1'b1} << cur_q;

endmodule

// File: tb/tb_key_cmd_fsm.sv
// Bench for key_cmd_fsm: directed scenarios plus random
// scan-byte streams compared against a key-level model.
module tb_key_cmd_fsm;

  localparam int NN = 8;
  localparam int NO = 4;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_en;
  logic       mode;
  logic [2:0] cursor;
  logic [7:0] note_array;
  logic [1:0] octave;
  logic       play_tick;

  key_cmd_fsm #(
    .NUM_NOTES(NN),
    .NUM_OCT(NO),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .rx_en        (rx_en),
    .mode         (mode),
    .cursor       (cursor),
    .note_array   (note_array),
    .octave       (octave),
    .play_tick    (play_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit cmp_en = 0;
  bit prev_play = 0;

  // Model: prefix bytes kept as a list, held keys by name
  byte unsigned pfx[$];
  bit  held[string];
  int  idle_n = 0;
  bit  m_rx_en = 0;
  bit  m_mode = 0;
  int  m_cur = 0;
  int  m_oct = 0;
  bit  m_play = 0;

  function automatic string key_name(bit ext, byte unsigned c);
    if (!ext) begin
      if (c == 8'h4B) return "L";
      if (c == 8'h4D) return "P";
      if (c == 8'h29) return "SPACE";
    end else begin
      if (c == 8'h75) return "UP";
      if (c == 8'h72) return "DOWN";
      if (c == 8'h6B) return "LEFT";
      if (c == 8'h74) return "RIGHT";
    end
    return "";
  endfunction

  task automatic apply_key(bit ext, bit brk, byte unsigned c);
    string k;
    k = key_name(ext, c);
    if (k == "") return;
    if (brk) begin
      if (held.exists(k)) held.delete(k);
      return;
    end
    if (held.exists(k)) return;
    held[k] = 1;
    if (k == "L") m_mode = 0;
    else if (k == "P") m_mode = 1;
    else if (m_mode) begin
      if (k == "RIGHT") m_cur = (m_cur + 1) % NN;
      if (k == "LEFT") m_cur = (m_cur + NN - 1) % NN;
      if (k == "UP" && m_oct < NO - 1) m_oct++;
      if (k == "DOWN" && m_oct > 0) m_oct--;
      if (k == "SPACE") m_play = 1;
    end
  endtask

  always @(posedge clk) begin
    m_play = 0;
    if (reset) begin
      m_rx_en = 0; m_mode = 0; m_cur = 0; m_oct = 0;
      pfx.delete(); held.delete(); idle_n = 0;
    end else begin
      m_rx_en = 1;
      if (rx_done_tick) begin
        idle_n = 0;
        if (pfx.size() == 0 &&
            (rx_data == 8'hE0 || rx_data == 8'hF0)) begin
          pfx.push_back(rx_data);
        end else if (pfx.size() == 1 && pfx[0] == 8'hE0 &&
                     rx_data == 8'hE0) begin
          pfx.push_back(8'h00);
          void'(pfx.pop_back());
        end else if (pfx.size() == 1 && pfx[0] == 8'hE0 &&
                     rx_data == 8'hF0) begin
          pfx.push_back(rx_data);
        end else begin
          apply_key(pfx.size() > 0 && pfx[0] == 8'hE0,
                    pfx.size() > 0 && pfx[pfx.size()-1] == 8'hF0,
                    rx_data);
          pfx.delete();
        end
      end else if (pfx.size() != 0) begin
        idle_n++;
        if (idle_n == TO) begin
          pfx.delete();
          idle_n = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (rx_en !== m_rx_en || mode !== m_mode ||
          cursor !== 3'(m_cur) || octave !== 2'(m_oct) ||
          note_array !== 8'(1 << m_cur) ||
          play_tick !== m_play) begin
        errors++;
        $display("FAIL model t=%0t got en=%b md=%b cur=%0d na=%h oct=%0d pt=%b need en=%b md=%b cur=%0d na=%h oct=%0d pt=%b",
          $time, rx_en, mode, cursor, note_array, octave,
          play_tick, m_rx_en, m_mode, m_cur, 8'(1 << m_cur),
          m_oct, m_play);
      end
      checks++;
      if (play_tick === 1'b1 && prev_play) begin
        errors++;
        $display("FAIL play_consecutive t=%0t got 1 need 0",
                 $time);
      end
      prev_play = (play_tick === 1'b1);
      if (play_tick === 1'b1) pulses++;
    end
  end

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d need %0d", name, got, exp);
    end
  endtask

  task automatic send_raw(byte unsigned b);
    rx_done_tick = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(byte unsigned b);
    send_raw(b);
    idle(3);
  endtask

  task automatic pair_ext(byte unsigned b);
    send(8'hE0); send(b);
    send(8'hE0); send(8'hF0); send(b);
  endtask

  byte unsigned pool[10] = '{8'hE0, 8'hF0, 8'h4B, 8'h4D,
    8'h29, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h12};

  initial begin
    int p0;
    @(posedge clk);
    cmp_en = 1;
    @(negedge clk);
    chk("reset_rx_en", int'(rx_en), 0);
    chk("reset_note", int'(note_array), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("rx_en_after_reset", int'(rx_en), 1);

    send(8'h4D); send(8'hF0); send(8'h4D);
    send(8'hE0); send(8'h74);
    send(8'hE0); send(8'hF0); send(8'h74);
    chk("t1_mode", int'(mode), 1);
    chk("t1_cursor", int'(cursor), 1);
    chk("t1_note", int'(note_array), 8'h02);
    chk("t1_play", int'(play_tick), 0);

    p0 = pulses;
    send(8'h29); send(8'h29); send(8'h29);
    send(8'hF0); send(8'h29); send(8'h29);
    send(8'hF0); send(8'h29);
    chk("typematic_pulses", pulses - p0, 2);

    pair_ext(8'h6B);
    pair_ext(8'h6B);
    chk("wrap_cursor", int'(cursor), 7);
    chk("wrap_note", int'(note_array), 8'h80);
    repeat (5) pair_ext(8'h75);
    chk("oct_sat_hi", int'(octave), 3);
    repeat (4) pair_ext(8'h72);
    chk("oct_sat_lo", int'(octave), 0);

    send(8'h4B); send(8'hF0); send(8'h4B);
    p0 = pulses;
    send(8'hE0); send(8'h74);
    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'h29); send(8'hF0); send(8'h29);
    chk("listen_cursor", int'(cursor), 7);
    chk("listen_octave", int'(octave), 0);
    chk("listen_play", pulses - p0, 0);
    send(8'h4D);
    chk("listen_to_play", int'(mode), 1);
    send(8'hF0); send(8'h4D);

    send_raw(8'hE0);
    idle(19);
    send(8'h74);
    chk("timeout_ignored", int'(cursor), 7);
    send_raw(8'hE0);
    idle(15);
    send(8'h74);
    chk("expiry_byte_wins", int'(cursor), 0);
    send(8'hE0); send(8'hF0); send(8'h74);

    send(8'h4D);
    send_raw(8'hE0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send(8'h74);
    chk("rst_mode", int'(mode), 0);
    chk("rst_cursor", int'(cursor), 0);
    chk("rst_octave", int'(octave), 0);
    chk("rst_rx_en", int'(rx_en), 1);

    send(8'h4D);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      if ($urandom_range(0, 11) == 0)
        send_raw(8'($urandom_range(0, 255)));
      else
        send_raw(pool[$urandom_range(0, 9)]);
      idle($urandom_range(1, 20));
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
